// File: rtl/abs_16.sv
// Registered signed absolute-value unit: abs_a = |a| one cycle after in_valid.
// Optional macro ABS16_SATURATE_EN clamps the most-negative input to 2^(N-1)-1 instead of wrapping.
module abs_16 #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] a,
  output logic         out_valid,
  output logic [N-1:0] abs_a,
  output logic         ovf
);

  localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] MOST_POS = {1'b0, {(N-1){1'b1}}};

  logic         valid_d, valid_q;
  logic [N-1:0] abs_d, abs_q;
  logic         ovf_d, ovf_q;
  logic         is_most_neg;
  logic [N-1:0] negated;
  logic [N-1:0] magnitude;

  always_comb begin
    is_most_neg = (a == MOST_NEG);
    negated     = (~a) + {{(N-1){1'b0}}, 1'b1};
    magnitude   = a[N-1] ? negated : a;
`ifdef ABS16_SATURATE_EN
    if (is_most_neg) begin
      magnitude = MOST_POS;
    end
`endif
  end

  // Capture is enable-gated so an idle (possibly X) operand never reaches the registers.
  always_comb begin
    valid_d = in_valid;
    abs_d   = abs_q;
    ovf_d   = ovf_q;
    if (in_valid) begin
      abs_d = magnitude;
      ovf_d = is_most_neg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      abs_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      abs_q   <= abs_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = valid_q;
  assign abs_a     = abs_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_abs_16.sv
// Directed self-checking bench for abs_16 (N=16): reset, full operand sweep, gaps,
// back-to-back and mid-stream reset. Honours ABS16_SATURATE_EN for the most-negative case.
module tb_abs_16;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] a;
  logic        out_valid;
  logic [15:0] abs_a;
  logic        ovf;

  int n_vec;
  int n_bad;

`ifdef ABS16_SATURATE_EN
  localparam logic [15:0] MINNEG_EXP = 16'h7FFF;
`else
  localparam logic [15:0] MINNEG_EXP = 16'h8000;
`endif

  abs_16 #(.N(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .a        (a),
    .out_valid(out_valid),
    .abs_a    (abs_a),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs, then sample 1 time unit after the edge that captures them.
  task automatic step(input logic r, input logic v, input logic [15:0] val);
    rst      = r;
    in_valid = v;
    a        = val;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [15:0] m, input logic o);
    check({tag, ".out_valid"}, {15'd0, out_valid}, {15'd0, v});
    check({tag, ".abs_a"}, abs_a, m);
    check({tag, ".ovf"}, {15'd0, ovf}, {15'd0, o});
  endtask

  initial begin
    int e;
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1; in_valid = 1'b0; a = 16'h0000;
    #1;

    // Reset held for two cycles with a valid operand pending.
    step(1'b1, 1'b1, 16'h8001); check_out("rst_hold0", 1'b0, 16'h0000, 1'b0);
    step(1'b1, 1'b1, 16'h8001); check_out("rst_hold1", 1'b0, 16'h0000, 1'b0);
    step(1'b0, 1'b1, 16'h8001); check_out("rst_first", 1'b1, 16'h7FFF, 1'b0);

    // Full sweep of every 16-bit operand.
    for (int i = -32768; i <= 32767; i++) begin
      step(1'b0, 1'b1, i[15:0]);
      if (i == -32768) begin
        check_out("sweep_minneg", 1'b1, MINNEG_EXP, 1'b1);
      end else begin
        e = (i < 0) ? -i : i;
        check_out("sweep", 1'b1, e[15:0], 1'b0);
      end
    end

    // Named corner operands.
    step(1'b0, 1'b1, 16'hFFFF); check_out("neg_one", 1'b1, 16'h0001, 1'b0);
    step(1'b0, 1'b1, 16'h0000); check_out("zero", 1'b1, 16'h0000, 1'b0);
    step(1'b0, 1'b1, 16'h7FFF); check_out("max_pos", 1'b1, 16'h7FFF, 1'b0);
    step(1'b0, 1'b1, 16'h8001); check_out("neg_max", 1'b1, 16'h7FFF, 1'b0);
    step(1'b0, 1'b1, 16'h8000); check_out("most_neg", 1'b1, MINNEG_EXP, 1'b1);

    // Valid gaps: result holds while idle, including an X operand.
    step(1'b0, 1'b1, 16'hFFFB); check_out("gap_m5", 1'b1, 16'h0005, 1'b0);
    step(1'b0, 1'b0, 16'h1234); check_out("gap_idle0", 1'b0, 16'h0005, 1'b0);
    step(1'b0, 1'b0, 16'h1234); check_out("gap_idle1", 1'b0, 16'h0005, 1'b0);
    step(1'b0, 1'b0, 16'h1234); check_out("gap_idle2", 1'b0, 16'h0005, 1'b0);
    step(1'b0, 1'b0, 16'hxxxx); check_out("gap_idle_x", 1'b0, 16'h0005, 1'b0);

    // Back-to-back operands, ovf only on the most-negative one.
    step(1'b0, 1'b1, 16'hFF9C); check_out("b2b_m100", 1'b1, 16'd100, 1'b0);
    step(1'b0, 1'b1, 16'd100);  check_out("b2b_p100", 1'b1, 16'd100, 1'b0);
    step(1'b0, 1'b1, 16'h8000); check_out("b2b_minneg", 1'b1, MINNEG_EXP, 1'b1);
    step(1'b0, 1'b1, 16'd7);    check_out("b2b_p7", 1'b1, 16'd7, 1'b0);

    // Reset in the cycle -9 is valid drops it.
    step(1'b1, 1'b1, 16'hFFF7); check_out("mid_rst", 1'b0, 16'h0000, 1'b0);
    step(1'b0, 1'b0, 16'h0000); check_out("mid_rst_after", 1'b0, 16'h0000, 1'b0);
    step(1'b0, 1'b1, 16'hFFF7); check_out("mid_rst_resume", 1'b1, 16'd9, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
